// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the write-back port arbiter:
//   REG_ADDR_W / XLEN - register address and data widths
//   arb_state_e       - arbiter FSM states
//   grant_e           - which requester owns the register-file port this cycle
//   pend_entry_t      - one pending-result buffer entry {valid, rd, data}
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    ST_IDLE,     // buffer holds no live entry
    ST_PENDING,  // live entries waiting, starvation counter running
    ST_FORCE     // head must be written this cycle, pipe is stalled
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_HEAD,
    GNT_EXT
  } grant_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } pend_entry_t;

endpackage : wb_arb_pkg

// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles every non-clock signal of the write-back port arbiter.
//   slave  modport : arbiter side (consumes pipe/ext/decode, drives rf port)
//   master modport : core side (drives pipe/ext/decode, sees rf port)
// Signals:
//   pipe_we/pipe_rd/pipe_wdata   WB-stage write request
//   pipe_stall                   hold WB and upstream
//   ext_valid/ext_rd/ext_wdata   long-latency result offer
//   ext_ready                    arbiter accepts the ext result
//   rs1_addr/rs2_addr, hazard    decode source lookup against the buffer
//   rf_we/rf_waddr/rf_wdata      the single register-file write port
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if;
  import wb_arb_pkg::*;

  logic                  pipe_we;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0]       pipe_wdata;
  logic                  pipe_stall;

  logic                  ext_valid;
  logic [REG_ADDR_W-1:0] ext_rd;
  logic [XLEN-1:0]       ext_wdata;
  logic                  ext_ready;

  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic                  hazard;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;

  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata,
    input  ext_valid, ext_rd, ext_wdata,
    input  rs1_addr, rs2_addr,
    output pipe_stall, ext_ready, hazard,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output pipe_we, pipe_rd, pipe_wdata,
    output ext_valid, ext_rd, ext_wdata,
    output rs1_addr, rs2_addr,
    input  pipe_stall, ext_ready, hazard,
    input  rf_we, rf_waddr, rf_wdata
  );

endinterface : wb_port_arbiter_if

// File: rtl/wb_pend_fifo.sv
// -----------------------------------------------------------------------------
// wb_pend_fifo
// DEPTH-entry circular buffer of pending long-latency results.
// Entries can be killed by destination register; dead entries ahead of the
// first live one are retired in the same cycle without using the port.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   push_i, push_rd_i/data_i   enqueue at tail (caller guarantees not full)
//   pop_i                      retire the live head (written to the rf)
//   kill_i, kill_rd_i          invalidate every live entry with rd == kill_rd_i
//   head_o                     first live entry (head_o.valid = one exists)
//   count_o                    occupied slots, dead-but-unretired included
//   any_valid_next_o           a live entry will remain after this cycle
//   valid_o, rd_o              per-slot liveness and destination for lookup
// -----------------------------------------------------------------------------
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_rd_i,
  input  logic [XLEN-1:0]       push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  logic [REG_ADDR_W-1:0] kill_rd_i,
  output pend_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  any_valid_next_o,
  output logic [DEPTH-1:0]      valid_o,
  output logic [REG_ADDR_W-1:0] rd_o [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  head_found;
  logic [PTR_W-1:0]      head_idx;
  logic [CNT_W-1:0]      skip;
  logic [CNT_W-1:0]      deq;

  // Find the first live slot from the read pointer. Free slots always carry
  // valid=0, so scanning all DEPTH slots never lands past the tail. With no
  // live slot every occupied slot is dead and is retired at once.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    head_found = 1'b0;
    head_idx   = rd_ptr_q;
    skip       = count_q;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[rd_ptr_q + PTR_W'(i)]) begin
        head_found = 1'b1;
        head_idx   = rd_ptr_q + PTR_W'(i);
        skip       = CNT_W'(i);
      end
    end
  end

  always_comb begin
    deq      = skip + CNT_W'(pop_i && head_found);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    count_d  = count_q - deq + CNT_W'(push_i);

    valid_d = valid_q;
    if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (rd_q[i] == kill_rd_i)) valid_d[i] = 1'b0;
      end
    end
    if (pop_i && head_found) valid_d[head_idx] = 1'b0;
    if (push_i)              valid_d[wr_ptr_q] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: payload storage is not reset; the valid bits alone decide whether a
  // slot means anything, so resetting rd/data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_q[wr_ptr_q]   <= push_rd_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o           = '{valid: head_found, rd: rd_q[head_idx], data: data_q[head_idx]};
  assign count_o          = count_q;
  assign any_valid_next_o = |valid_d;
  assign valid_o          = valid_q;
  assign rd_o             = rd_q;

endmodule : wb_pend_fifo

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares one register-file write port between the in-order WB stage and a
// long-latency unit. Ext results that cannot be written immediately wait in
// wb_pend_fifo; a starvation FSM forces the oldest one through by stalling
// the pipe for a single cycle.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         wb_port_arbiter_if.slave (pipe, ext, decode lookup, rf port)
// Parameters:
//   DEPTH         pending-buffer entries (power of two, >= 2)
//   STARVE_LIMIT  denied PENDING cycles before the head is forced
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    DEPTH_C      = CNT_W'(DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_LAST  = STARVE_W'(STARVE_LIMIT - 1);

  arb_state_e            state_q;
  logic [STARVE_W-1:0]   starve_q;
  logic                  stall_q;
  logic                  active_q;   // low until the first edge after reset

  pend_entry_t           head;
  logic [CNT_W-1:0]      count;
  logic                  any_valid_next;
  logic [DEPTH-1:0]      ent_valid;
  logic [REG_ADDR_W-1:0] ent_rd [DEPTH];

  logic                  ext_ready;
  logic                  pipe_ok;
  logic                  ext_ok;
  grant_e                grant;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic                  hazard;

  // Ready depends only on flops, so ext_valid/pipe_we never loop back into it.
  assign ext_ready = active_q && (count < DEPTH_C);
  assign pipe_ok   = bus.pipe_we && (bus.pipe_rd != '0);
  // An ext transfer to x0 completes but is neither written nor buffered.
  assign ext_ok    = bus.ext_valid && ext_ready && (bus.ext_rd != '0);

  always_comb begin
    grant = GNT_NONE;
    if (active_q) begin
      if (state_q == ST_FORCE) begin
        if (head.valid) grant = GNT_HEAD;
      end else if (pipe_ok) begin
        grant = GNT_PIPE;
      end else if (head.valid) begin
        grant = GNT_HEAD;
      end else if (ext_ok) begin
        grant = GNT_EXT;
      end
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (grant)
      GNT_PIPE: begin rf_we = 1'b1; rf_waddr = bus.pipe_rd; rf_wdata = bus.pipe_wdata; end
      GNT_HEAD: begin rf_we = 1'b1; rf_waddr = head.rd;     rf_wdata = head.data;      end
      GNT_EXT:  begin rf_we = 1'b1; rf_waddr = bus.ext_rd;  rf_wdata = bus.ext_wdata;  end
      default:  ;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        if ((bus.rs1_addr != '0) && (bus.rs1_addr == ent_rd[i])) hazard = 1'b1;
        if ((bus.rs2_addr != '0) && (bus.rs2_addr == ent_rd[i])) hazard = 1'b1;
      end
    end
  end

  // A granted pipe write is younger than anything buffered for the same rd,
  // so those buffered results must never reach the register file.
  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_i           (ext_ok && (grant != GNT_EXT)),
    .push_rd_i        (bus.ext_rd),
    .push_data_i      (bus.ext_wdata),
    .pop_i            (grant == GNT_HEAD),
    .kill_i           (grant == GNT_PIPE),
    .kill_rd_i        (bus.pipe_rd),
    .head_o           (head),
    .count_o          (count),
    .any_valid_next_o (any_valid_next),
    .valid_o          (ent_valid),
    .rd_o             (ent_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      stall_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      stall_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          starve_q <= '0;
          if (any_valid_next) state_q <= ST_PENDING;
        end
        ST_PENDING: begin
          if (!any_valid_next) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
          end else if (grant == GNT_HEAD) begin
            starve_q <= '0;
          end else if (starve_q == STARVE_LAST) begin
            state_q  <= ST_FORCE;
            starve_q <= '0;
            stall_q  <= 1'b1;
          end else begin
            starve_q <= starve_q + 1'b1;
          end
        end
        ST_FORCE: begin
          starve_q <= '0;
          state_q  <= any_valid_next ? ST_PENDING : ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          starve_q <= '0;
        end
      endcase
    end
  end

  assign bus.ext_ready  = ext_ready;
  assign bus.pipe_stall = stall_q;
  assign bus.hazard     = hazard;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_port_arbiter_if arb_if ();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        valid;
    bit [4:0]  rd;
    bit [31:0] data;
  } m_ent_t;

  m_ent_t mq[$];       // occupied slots, oldest first
  int     m_starve;
  bit     m_force;
  bit     m_active;
  int     g_kind;      // 0 none, 1 pipe, 2 buffered head, 3 ext bypass
  int     g_head;      // index of first live entry, -1 if none
  bit     e_ready;

  logic        obs_we, obs_stall, obs_ready, obs_hazard;
  logic [4:0]  obs_waddr;
  logic [31:0] obs_wdata;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_force  = 0;
    m_active = 0;
  endtask

  task automatic model_update();
    bit xfer, any_before, any_after, was_force;
    int drop;
    xfer       = arb_if.ext_valid && e_ready;
    any_before = (g_head >= 0);
    was_force  = m_force;
    drop       = (g_head >= 0) ? g_head : mq.size();
    repeat (drop) void'(mq.pop_front());
    if (g_kind == 2) void'(mq.pop_front());
    if (g_kind == 1) foreach (mq[i]) if (mq[i].rd == arb_if.pipe_rd) mq[i].valid = 0;
    if (xfer && arb_if.ext_rd != 0 && g_kind != 3)
      mq.push_back('{valid: 1'b1, rd: arb_if.ext_rd, data: arb_if.ext_wdata});
    any_after = 0;
    foreach (mq[i]) if (mq[i].valid) any_after = 1;
    if (was_force) begin
      m_force  = 0;
      m_starve = 0;
    end else if (any_before) begin
      if (g_kind == 2) m_starve = 0;
      else             m_starve++;
      if (!any_after) m_starve = 0;
      else if (m_starve == LIMIT) begin
        m_force  = 1;
        m_starve = 0;
      end
    end else begin
      m_starve = 0;
    end
    m_active = 1;
  endtask

  // One clock: compare outputs at the falling edge, advance the model at the
  // rising edge, return 1 time unit later so the caller can drive new inputs.
  task automatic step();
    bit        e_we, e_hz, pipe_ok;
    bit [4:0]  e_addr;
    bit [31:0] e_data;
    @(negedge clk);
    g_head = -1;
    foreach (mq[i]) if (mq[i].valid && g_head < 0) g_head = i;
    e_ready = m_active && (mq.size() < DEPTH);
    pipe_ok = arb_if.pipe_we && (arb_if.pipe_rd != 0);
    g_kind  = 0;
    if (m_active) begin
      if (m_force)           g_kind = (g_head >= 0) ? 2 : 0;
      else if (pipe_ok)      g_kind = 1;
      else if (g_head >= 0)  g_kind = 2;
      else if (arb_if.ext_valid && e_ready && arb_if.ext_rd != 0) g_kind = 3;
    end
    e_we = (g_kind != 0);
    e_addr = 0;
    e_data = 0;
    case (g_kind)
      1: begin e_addr = arb_if.pipe_rd;  e_data = arb_if.pipe_wdata;  end
      2: begin e_addr = mq[g_head].rd;   e_data = mq[g_head].data;    end
      3: begin e_addr = arb_if.ext_rd;   e_data = arb_if.ext_wdata;   end
      default: ;
    endcase
    e_hz = 0;
    foreach (mq[i])
      if (mq[i].valid && ((arb_if.rs1_addr != 0 && mq[i].rd == arb_if.rs1_addr) ||
                          (arb_if.rs2_addr != 0 && mq[i].rd == arb_if.rs2_addr))) e_hz = 1;
    obs_we     = arb_if.rf_we;
    obs_waddr  = arb_if.rf_waddr;
    obs_wdata  = arb_if.rf_wdata;
    obs_stall  = arb_if.pipe_stall;
    obs_ready  = arb_if.ext_ready;
    obs_hazard = arb_if.hazard;
    check("ext_ready", obs_ready, e_ready);
    check("pipe_stall", obs_stall, m_force);
    check("hazard", obs_hazard, e_hz);
    check("rf_we", obs_we, e_we);
    if (e_we) begin
      check("rf_waddr", obs_waddr, e_addr);
      check("rf_wdata", obs_wdata, e_data);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Called 1 time unit after a rising edge; releases at the same phase.
  task automatic reset_phase(input int hold);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ext_ready", arb_if.ext_ready, 0);
    check("rst_rf_we", arb_if.rf_we, 0);
    check("rst_pipe_stall", arb_if.pipe_stall, 0);
    check("rst_hazard", arb_if.hazard, 0);
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_pipe(input bit we, input bit [4:0] rd, input bit [31:0] data);
    arb_if.pipe_we    = we;
    arb_if.pipe_rd    = rd;
    arb_if.pipe_wdata = data;
  endtask

  task automatic set_ext(input bit valid, input bit [4:0] rd, input bit [31:0] data);
    arb_if.ext_valid = valid;
    arb_if.ext_rd    = rd;
    arb_if.ext_wdata = data;
  endtask

  initial begin
    rst_n = 1'b0;
    set_pipe(1, 3, 32'h3333_3333);   // must not reach the rf during reset
    set_ext(0, 0, 0);
    arb_if.rs1_addr = 0;
    arb_if.rs2_addr = 0;
    model_reset();
    #1;
    check("init_rf_we", arb_if.rf_we, 0);
    check("init_ext_ready", arb_if.ext_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_pipe(0, 0, 0);
    step();
    step();
    check("release_ready", obs_ready, 1);

    // Idle bypass: ext result written the same cycle, nothing buffered.
    set_ext(1, 5, 32'hA5A5_A5A5);
    arb_if.rs1_addr = 5;
    step();
    check("bypass_we", obs_we, 1);
    check("bypass_waddr", obs_waddr, 5);
    check("bypass_wdata", obs_wdata, 32'hA5A5_A5A5);
    set_ext(0, 0, 0);
    step();
    check("bypass_no_hazard", obs_hazard, 0);
    check("bypass_buffer_empty_we", obs_we, 0);

    // Contention: pipe owns the port, x6 and x7 fill the buffer, x8 refused.
    set_pipe(1, 10, 32'h100); set_ext(1, 6, 32'h66);
    step();
    set_pipe(1, 11, 32'h101); set_ext(1, 7, 32'h77);
    step();
    check("x7_accepted", obs_ready, 1);
    set_pipe(1, 12, 32'h102); set_ext(1, 8, 32'h88);
    arb_if.rs1_addr = 6;
    step();
    check("full_not_ready", obs_ready, 0);
    check("x6_hazard", obs_hazard, 1);
    set_ext(0, 0, 0);

    // Starvation: fourth denied cycle leads to one forced head write.
    set_pipe(1, 13, 32'h103); step();
    set_pipe(1, 14, 32'h104); step();
    check("pre_force_stall", obs_stall, 0);
    set_pipe(1, 15, 32'h105); step();
    check("force1_stall", obs_stall, 1);
    check("force1_waddr", obs_waddr, 6);
    check("force1_wdata", obs_wdata, 32'h66);
    step();   // held pipe request granted now
    check("held_pipe_stall", obs_stall, 0);
    check("held_pipe_waddr", obs_waddr, 15);
    set_pipe(1, 16, 32'h106); step();
    set_pipe(1, 17, 32'h107); step();
    set_pipe(1, 18, 32'h108); step();
    check("pre_force2_stall", obs_stall, 0);
    set_pipe(1, 19, 32'h109); step();
    check("force2_stall", obs_stall, 1);
    check("force2_waddr", obs_waddr, 7);
    step();
    check("force2_held_waddr", obs_waddr, 19);

    // WAW: buffered x9 is killed by a younger pipe write to x9.
    set_pipe(1, 12, 32'h10C); set_ext(1, 9, 32'h11);
    step();
    set_ext(0, 0, 0);
    set_pipe(1, 9, 32'h22);
    arb_if.rs1_addr = 9;
    step();
    check("waw_hazard_before", obs_hazard, 1);
    check("waw_pipe_wdata", obs_wdata, 32'h22);
    set_pipe(0, 0, 0);
    step();
    check("waw_hazard_after", obs_hazard, 0);
    check("waw_killed_not_written", obs_we, 0);
    step();
    check("waw_killed_not_written2", obs_we, 0);

    // rd==0 ext transfer completes without a write.
    set_ext(1, 0, 32'hDEAD_BEEF);
    step();
    check("rd0_accepted", obs_ready, 1);
    check("rd0_no_write", obs_we, 0);

    // Reset with two entries pending drops them.
    set_pipe(1, 13, 32'h113); set_ext(1, 20, 32'h20);
    step();
    set_ext(1, 21, 32'h21);
    step();
    set_ext(0, 0, 0);
    arb_if.rs1_addr = 20;
    reset_phase(2);
    set_pipe(0, 0, 0);
    step();
    step();
    check("post_rst_ready", obs_ready, 1);
    check("post_rst_no_write", obs_we, 0);
    step();
    check("post_rst_no_write2", obs_we, 0);

    // Randomized traffic: pipe request held across a stall, ext offer held
    // until accepted.
    for (int n = 0; n < 800; n++) begin
      if (n == 400) reset_phase(1);
      if (!obs_stall) begin
        arb_if.pipe_we    = ($urandom_range(0, 99) < 70);
        arb_if.pipe_rd    = 5'($urandom_range(0, 7));
        arb_if.pipe_wdata = $urandom;
      end
      if (!(arb_if.ext_valid && !obs_ready)) begin
        arb_if.ext_valid = ($urandom_range(0, 99) < 50);
        arb_if.ext_rd    = 5'($urandom_range(0, 7));
        arb_if.ext_wdata = $urandom;
      end
      arb_if.rs1_addr = 5'($urandom_range(0, 7));
      arb_if.rs2_addr = 5'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_port_arbiter
